// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one TX_SEND byte serializer
// among NREQ requesters, with a stall timeout that reclaims an abandoned path.

module uart_tx_arbiter_lane #(
  parameter int DW = 8
) (
  input  logic          sel,
  input  logic          wen,
  input  logic [DW-1:0] data,
  output logic          ready,
  output logic [DW-1:0] dout
);
  assign ready = sel & wen;
  assign dout  = sel ? data : '0;
endmodule

module uart_tx_arbiter #(
  parameter  int NREQ    = 4,
  parameter  int DW      = 8,
  parameter  int TIMEOUT = 1024,
  localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               CLK,
  input  logic               RST_X,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ready,
  output logic               tx_wen,
  output logic [DW-1:0]      tx_din,
  input  logic               tx_rdy,
  output logic [NREQ-1:0]    grant,
  output logic               busy,
  output logic               timeout_err,
  output logic [IW-1:0]      timeout_id
);

  localparam bit          TO_EN = (TIMEOUT != 0);
  localparam logic [15:0] TO_M1 = 16'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t                     state, state_nxt;
  logic [IW-1:0]              own, last_owner, win;
  logic                       guard, any_req, found, done, stall, to_hit;
  logic [15:0]                cnt;
  logic [NREQ-1:0][DW-1:0]    lane_dout;

  // Search above last_owner first, then wrap from 0.
  always_comb begin
    any_req = |req_valid;
    found   = 1'b0;
    win     = '0;
    for (int i = 0; i < NREQ; i++)
      if (!found && req_valid[i] && (IW'(i) > last_owner)) begin
        found = 1'b1;
        win   = IW'(i);
      end
    for (int i = 0; i < NREQ; i++)
      if (!found && req_valid[i]) begin
        found = 1'b1;
        win   = IW'(i);
      end
  end

  assign done   = tx_wen & req_last[own];
  assign stall  = (state == LOCK) & ~req_valid[own];
  assign to_hit = TO_EN && stall && (cnt == TO_M1);

  always_ff @(posedge CLK or negedge RST_X)
    if (!RST_X) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = LOCK;
      LOCK:    if (done || to_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // guard masks the cycle after a write, when TX_SEND may not yet have dropped rdy.
  always_comb begin
    busy   = (state == LOCK);
    tx_wen = (state == LOCK) & req_valid[own] & tx_rdy & ~guard;
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      grant       <= '0;
      own         <= '0;
      last_owner  <= IW'(NREQ - 1);
      guard       <= 1'b0;
      cnt         <= '0;
      timeout_err <= 1'b0;
      timeout_id  <= '0;
    end else begin
      timeout_err <= 1'b0;
      guard       <= tx_wen;
      case (state)
        IDLE: if (any_req) begin
          grant <= NREQ'(1) << win;
          own   <= win;
          cnt   <= '0;
        end
        LOCK: if (tx_wen) begin
          cnt <= '0;
          if (req_last[own]) begin
            grant      <= '0;
            last_owner <= own;
          end
        end else if (to_hit) begin
          grant       <= '0;
          last_owner  <= own;
          timeout_err <= 1'b1;
          timeout_id  <= own;
        end else if (stall) begin
          cnt <= cnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  // grant is one-hot only in LOCK, so the lane OR yields 0 when idle.
  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    uart_tx_arbiter_lane #(.DW(DW)) u_lane (
      .sel   (grant[i]),
      .wen   (tx_wen),
      .data  (req_data[i*DW +: DW]),
      .ready (req_ready[i]),
      .dout  (lane_dout[i])
    );
  end

  always_comb begin
    tx_din = '0;
    for (int i = 0; i < NREQ; i++) tx_din = tx_din | lane_dout[i];
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: queued requester stimulus, a TX_SEND
// model that drops rdy one cycle late, and a negedge monitor doing all checks.

module tb_uart_tx_arbiter;
  localparam int NREQ = 4, DW = 8, TIMEOUT = 50;

  logic               CLK = 1'b0, RST_X = 1'b0;
  logic [NREQ-1:0]    req_valid, req_last, req_ready, grant;
  logic [NREQ*DW-1:0] req_data;
  logic               tx_wen, tx_rdy, busy, timeout_err;
  logic [DW-1:0]      tx_din;
  logic [1:0]         timeout_id;

  always #5 CLK = ~CLK;

  uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST_X(RST_X), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_wen(tx_wen), .tx_din(tx_din),
    .tx_rdy(tx_rdy), .grant(grant), .busy(busy), .timeout_err(timeout_err),
    .timeout_id(timeout_id)
  );

  typedef struct { logic [7:0] d; logic l; } byte_t;
  typedef struct { int idx; logic [7:0] d; } exp_t;
  typedef struct { string nm; logic [31:0] act; logic [31:0] exp; } chk_t;

  byte_t rq[NREQ][$];
  exp_t  exp_q[$];
  chk_t  chk_q[$];
  int    pop_cyc[NREQ];
  int    cyc = 0;
  int    checks = 0, failures = 0;
  bit    rdy_en = 1'b1;
  logic  pend;
  logic [1:0] bcnt;
  logic [NREQ-1:0] drv_acc;

  always @(posedge CLK) cyc <= cyc + 1;

  // TX_SEND model: rdy stays high for the cycle after a write, then busy 2 cycles.
  always @(posedge CLK or negedge RST_X)
    if (!RST_X) begin
      pend <= 1'b0;
      bcnt <= 2'd0;
    end else begin
      pend <= tx_wen;
      if (pend) bcnt <= 2'd2;
      else if (bcnt != 0) bcnt <= bcnt - 2'd1;
    end
  assign tx_rdy = rdy_en && (bcnt == 2'd0);

  // Requester driver: presents queue heads, pops on acceptance.
  initial begin
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge CLK); drv_acc = req_ready;
      @(posedge CLK); #1;
      for (int i = 0; i < NREQ; i++)
        if (drv_acc[i] && rq[i].size() > 0) begin
          void'(rq[i].pop_front());
          pop_cyc[i] = cyc;
        end
      #1;
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i]         = rq[i].size() > 0;
        req_data[i*DW +: DW] = (rq[i].size() > 0) ? rq[i][0].d : 8'h00;
        req_last[i]          = (rq[i].size() > 0) ? rq[i][0].l : 1'b0;
      end
    end
  end

  // Monitor: evaluates posted checks and scoreboards every written byte.
  initial begin
    chk_t c;
    exp_t e;
    forever begin
      @(negedge CLK);
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        checks++;
        if (c.act !== c.exp) begin
          failures++;
          $display("FAIL %s: got %0h, expected %0h", c.nm, c.act, c.exp);
        end
      end
      if (RST_X) begin
        if (tx_wen) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: din=%h grant=%b", tx_din, grant);
          end else begin
            e = exp_q.pop_front();
            if (tx_din !== e.d || grant !== (NREQ'(1) << e.idx) ||
                req_ready !== (NREQ'(1) << e.idx) || !tx_rdy) begin
              failures++;
              $display("FAIL sb_byte: got din=%h grant=%b ready=%b rdy=%b, expected din=%h owner=%0d",
                       tx_din, grant, req_ready, tx_rdy, e.d, e.idx);
            end
          end
        end else if (req_ready != 0) begin
          checks++; failures++;
          $display("FAIL ready_without_wen: got ready=%b, expected 0", req_ready);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic post(input string nm, input logic [31:0] a, input logic [31:0] e);
    chk_t c;
    c.nm = nm; c.act = a; c.exp = e;
    chk_q.push_back(c);
  endtask

  task automatic stim(input int i, input logic [7:0] d, input bit l);
    byte_t b;
    b.d = d; b.l = l;
    rq[i].push_back(b);
  endtask

  task automatic expb(input int i, input logic [7:0] d);
    exp_t e;
    e.idx = i; e.d = d;
    exp_q.push_back(e);
  endtask

  function automatic bit all_empty();
    bit r = (exp_q.size() == 0);
    for (int i = 0; i < NREQ; i++) if (rq[i].size() != 0) r = 1'b0;
    return r;
  endfunction

  task automatic sync();
    @(posedge CLK); #3;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    while (!all_empty() && n < 3000) begin @(negedge CLK); n++; end
    post(nm, 32'(n < 3000), 1);
  endtask

  task automatic wait_q(input int i, input int sz, input string nm);
    int n = 0;
    while (rq[i].size() > sz && n < 3000) begin @(negedge CLK); n++; end
    post(nm, 32'(n < 3000), 1);
  endtask

  task automatic flush();
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    exp_q.delete();
  endtask

  task automatic chk_zero(input string p);
    post({p, "_grant"}, 32'(grant), 0);
    post({p, "_busy"}, 32'(busy), 0);
    post({p, "_wen"}, 32'(tx_wen), 0);
    post({p, "_din"}, 32'(tx_din), 0);
    post({p, "_ready"}, 32'(req_ready), 0);
    post({p, "_terr"}, 32'(timeout_err), 0);
    post({p, "_tid"}, 32'(timeout_id), 0);
  endtask

  task automatic do_reset();
    sync();
    RST_X = 1'b0;
    flush();
    repeat (2) @(posedge CLK);
    #3 RST_X = 1'b1;
  endtask

  initial begin
    int  c0, n;
    bit  any_wen, any_to;
    #12 chk_zero("por");
    sync(); RST_X = 1'b1;

    // 1: single requester "VER\r\n"
    sync();
    stim(2, 8'h56, 0); stim(2, 8'h45, 0); stim(2, 8'h52, 0); stim(2, 8'h0D, 0); stim(2, 8'h0A, 1);
    expb(2, 8'h56); expb(2, 8'h45); expb(2, 8'h52); expb(2, 8'h0D); expb(2, 8'h0A);
    wait_drain("t1_drain");
    post("t1_busy_after_last", 32'(busy), 0);
    post("t1_grant_after_last", 32'(grant), 0);

    // 2: four 2-byte messages, served 0..3, then again from 0 (wrap)
    do_reset();
    for (int r = 0; r < 2; r++) begin
      sync();
      for (int i = 0; i < NREQ; i++) begin
        stim(i, 8'(8'h10 + i), 0); stim(i, 8'(8'h20 + i), 1);
      end
      for (int i = 0; i < NREQ; i++) begin
        expb(i, 8'(8'h10 + i)); expb(i, 8'(8'h20 + i));
      end
      wait_drain("t2_drain");
    end

    // 3: after requester 1 finishes, 3 beats 1
    do_reset();
    sync(); stim(1, 8'h31, 1); expb(1, 8'h31);
    wait_drain("t3_first");
    sync();
    stim(1, 8'h41, 0); stim(1, 8'h42, 1); stim(3, 8'h43, 1);
    expb(3, 8'h43); expb(1, 8'h41); expb(1, 8'h42);
    wait_drain("t3_drain");

    // 4: requester 1 arrives mid-message and must wait
    do_reset();
    sync();
    stim(0, 8'hA0, 0); stim(0, 8'hA1, 0); stim(0, 8'hA2, 0); stim(0, 8'hA3, 1);
    expb(0, 8'hA0); expb(0, 8'hA1); expb(0, 8'hA2); expb(0, 8'hA3);
    wait_q(0, 3, "t4_first_byte");
    sync();
    stim(1, 8'hB0, 0); stim(1, 8'hB1, 1);
    expb(1, 8'hB0); expb(1, 8'hB1);
    @(negedge CLK);
    post("t4_grant_locked", 32'(grant), 32'h1);
    post("t4_ready1", 32'(req_ready[1]), 0);
    wait_drain("t4_drain");

    // 5: requester 2 abandons its message; timeout hands over to 3
    do_reset();
    sync();
    stim(2, 8'hC0, 0); stim(3, 8'hD0, 0); stim(3, 8'hD1, 1);
    expb(2, 8'hC0); expb(3, 8'hD0); expb(3, 8'hD1);
    wait_q(2, 0, "t5_byte");
    c0 = pop_cyc[2];
    n = 0;
    while (n < 200) begin
      @(negedge CLK); n++;
      if (timeout_err) break;
    end
    post("t5_seen", 32'(timeout_err), 1);
    post("t5_delay", 32'(cyc - c0), 50);
    post("t5_id", 32'(timeout_id), 2);
    @(negedge CLK);
    post("t5_pulse_width", 32'(timeout_err), 0);
    post("t5_grant", 32'(grant), 32'h8);
    wait_drain("t5_drain");
    post("t5_id_held", 32'(timeout_id), 2);

    // 6: long backpressure is not a stall; then async reset mid-message
    do_reset();
    sync();
    rdy_en = 1'b0;
    stim(0, 8'h60, 0); stim(0, 8'h61, 1); stim(1, 8'h70, 1);
    expb(0, 8'h60);
    any_wen = 0; any_to = 0;
    repeat (200) begin
      @(negedge CLK);
      if (tx_wen) any_wen = 1;
      if (timeout_err) any_to = 1;
    end
    post("t6_no_wen", 32'(any_wen), 0);
    post("t6_no_timeout", 32'(any_to), 0);
    post("t6_busy", 32'(busy), 1);
    post("t6_grant", 32'(grant), 32'h1);
    sync(); rdy_en = 1'b1;
    wait_q(0, 1, "t6_first_byte");
    sync();
    post("t6_pre_rst_busy", 32'(busy), 1);
    post("t6_sb_before_rst", 32'(exp_q.size()), 0);
    RST_X = 1'b0;
    #1 chk_zero("t6_rst");
    flush();
    repeat (2) @(posedge CLK);
    #3 RST_X = 1'b1;
    sync();
    stim(3, 8'hE3, 1); stim(0, 8'hE0, 1);
    expb(0, 8'hE0); expb(3, 8'hE3);
    wait_drain("t6_drain");

    post("sb_empty", 32'(exp_q.size()), 0);
    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
